spi_slave_shift: RTL and testbench
==================================

Name: spi_slave_shift

Overview:
- SPI target-side (slave) shifter: the receiving end of the SPI link whose master side drives SCLK from the divided clock generator.
- Oversamples external SCLK, CS_n and MOSI in the i_clk domain and recovers sample and shift edges for all four CPOL/CPHA modes.
- Deserialises MOSI into parallel words and serialises a one-entry TX holding buffer onto MISO.

Parameters:
- DATA_W, 8, word length in bits (2..32).
- SYNC_STAGES, 2, synchroniser depth for i_sclk, i_cs_n and i_mosi (>=2).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cpol  in  1  SCLK idle level.
- i_cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- i_lsb_first  in  1  1 = LSB shifted first on both MOSI and MISO.
- i_sclk  in  1  external SPI clock (asynchronous).
- i_cs_n  in  1  external chip select, active-low (asynchronous).
- i_mosi  in  1  external serial data in.
- o_miso  out  1  serial data out.
- o_miso_oe  out  1  MISO output enable; high while selected.
- i_tx_data  in  DATA_W  word to transmit.
- i_tx_valid  in  1  TX write request.
- o_tx_ready  out  1  TX holding register empty.
- o_rx_data  out  DATA_W  last complete received word.
- o_rx_valid  out  1  one-cycle pulse: o_rx_data updated.
- o_underrun  out  1  one-cycle pulse: word load found TX buffer empty.
- o_busy  out  1  high in ACTIVE state.

Behaviour:
- Reset values: o_miso=0, o_miso_oe=0, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_underrun=0, o_busy=0.
- Internal reset values: shift registers 0, bit counter 0, state IDLE, synchroniser flops 1 (CS), i_cpol (SCLK), 0 (MOSI).
- Synchronisation: i_sclk, i_cs_n and i_mosi each pass through SYNC_STAGES flops. Edge detection compares the last synchronised SCLK stage with one extra delayed flop.
- Timing requirement: each SCLK half-period >= SYNC_STAGES+3 i_clk cycles. Timing outside this range is unsupported and is not checked.
- Mode latch: i_cpol, i_cpha and i_lsb_first are latched on the synchronised CS falling edge and are ignored until the next CS fall.
- Edge classification:
  - leading edge = SCLK leaving the CPOL level; trailing edge = SCLK returning to it.
  - sample edge = leading if CPHA=0, trailing if CPHA=1.
  - shift edge = the other edge.
- FSM IDLE:
  - o_miso_oe=0, o_busy=0, bit counter held at 0.
  - Synchronised CS fall -> ACTIVE.
  - For CPHA=0, the same cycle performs a word load.
- FSM ACTIVE:
  - o_miso_oe=1, o_busy=1.
  - Sample edge: shift in the synchronised MOSI bit (into the LSB end, or the MSB end when i_lsb_first=1). Increment the bit counter.
  - On the DATA_W-th sample: o_rx_data = completed word, o_rx_valid pulses in the next i_clk cycle, bit counter wraps to 0.
  - Shift edge: advance the TX shift register and drive the next bit on o_miso.
    - CPHA=1 with bit counter 0: perform a word load instead of advancing.
    - CPHA=0 with bit counter 0 after a completed word: perform a word load (back-to-back transfer).
  - Synchronised CS rise -> IDLE from any bit count. A partial word is discarded with no o_rx_valid, and the bit counter clears.
- Word load:
  - If the TX buffer is full: copy it into the TX shift register and set o_tx_ready=1.
  - If the buffer is empty: load all-zeros and pulse o_underrun for 1 cycle.
  - After a load, o_miso = first bit (MSB, or LSB when i_lsb_first=1), registered, valid within 1 i_clk of the load.
- TX buffer:
  - Write when i_tx_valid && o_tx_ready; o_tx_ready falls the next cycle.
  - i_tx_valid while o_tx_ready=0 is ignored.
  - A write in the same cycle as a load of an empty buffer: the load takes the new data, no underrun, and o_tx_ready stays 1.
- Sample edge and CS rise in the same cycle: CS rise wins and the sample is discarded.
- Asynchronous reset mid-transfer: all state returns to reset values immediately. The next transfer starts only after a fresh synchronised CS fall.

Test Plan:
- Mode 0, MSB-first: preload tx=0x3C; master sends 0xA5 -> o_rx_data=0xA5 with a single o_rx_valid pulse; MISO bits captured by the master = 0x3C; o_tx_ready returns to 1 at CS fall.
- Mode 3 (CPOL=1, CPHA=1), LSB-first: tx=0x81, master sends 0x5A -> rx=0x5A, master receives 0x81; load occurs on the first leading edge.
- Back-to-back: tx 0x11, then write 0x22 during word 1, master sends 0xF0,0x0F under one CS -> two o_rx_valid pulses (0xF0, 0x0F), MISO carries 0x11 then 0x22, no underrun.
- Underrun: no tx write, 8 clocks -> MISO all 0, o_underrun pulses once at load, rx still valid.
- Abort: CS rises after 3 sample edges -> no o_rx_valid, o_busy=0; next full transfer of 0xC3 receives 0xC3 correctly.
- Reset mid-transfer: assert i_rst_n=0 after 5 bits -> all outputs at reset values; o_tx_ready=1; a subsequent transfer of 0x7E is received correctly.

Source files
------------

// File: rtl/spi_slave_shift.sv
// SPI target-side shifter: oversamples SCLK/CS_n/MOSI in the i_clk domain, deserialises MOSI
// into words and serialises a one-entry TX holding buffer onto MISO in all four CPOL/CPHA modes.
module spi_slave_shift #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_underrun,
    output logic              o_busy
);

    localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;

    logic                   cpol_l;
    logic                   cpha_l;
    logic                   lsb_l;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   word_done;
    logic [DATA_W-1:0]      rx_sh;
    logic [DATA_W-1:0]      tx_sh;
    logic [DATA_W-1:0]      tx_buf;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   tx_wr;
    logic                   do_load;
    logic                   load_lsb;
    logic [DATA_W-1:0]      load_word;
    logic [DATA_W-1:0]      rx_next;
    logic [DATA_W-1:0]      tx_next;
    logic                   miso_next;

    // Input synchronisers; SCLK idles at the CPOL level so no false edge follows reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync <= {SYNC_STAGES{i_cpol}};
            cs_sync   <= {SYNC_STAGES{1'b1}};
            mosi_sync <= '0;
            sclk_d    <= i_cpol;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    // Edge recovery, load decision and next shift-register values
    always_comb begin
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        cs_s        = cs_sync[SYNC_STAGES-1];
        mosi_s      = mosi_sync[SYNC_STAGES-1];
        cs_fall     = cs_d & ~cs_s;
        cs_rise     = ~cs_d & cs_s;
        lead_edge   = (sclk_s != sclk_d) && (sclk_d == cpol_l);
        trail_edge  = (sclk_s != sclk_d) && (sclk_s == cpol_l);
        sample_edge = cpha_l ? trail_edge : lead_edge;
        shift_edge  = cpha_l ? lead_edge : trail_edge;
        tx_wr       = i_tx_valid & o_tx_ready;

        do_load  = 1'b0;
        load_lsb = lsb_l;
        if (state == IDLE) begin
            // Mode latches are not yet updated on the CS-fall cycle, so use the live pins
            do_load  = cs_fall & ~i_cpha;
            load_lsb = i_lsb_first;
        end else if (!cs_rise && shift_edge && (bit_cnt == '0)) begin
            do_load = cpha_l | word_done;
        end

        load_word = '0;
        if (!o_tx_ready) begin
            load_word = tx_buf;
        end else if (tx_wr) begin
            load_word = i_tx_data;
        end

        rx_next   = lsb_l ? {mosi_s, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], mosi_s};
        tx_next   = lsb_l ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
        miso_next = lsb_l ? tx_sh[1] : tx_sh[DATA_W-2];
    end

    // Transfer FSM, TX holding buffer and shift registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cpol_l     <= 1'b0;
            cpha_l     <= 1'b0;
            lsb_l      <= 1'b0;
            bit_cnt    <= '0;
            word_done  <= 1'b0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            tx_buf     <= '0;
            o_miso     <= 1'b0;
            o_miso_oe  <= 1'b0;
            o_tx_ready <= 1'b1;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_underrun <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            o_underrun <= 1'b0;

            if (do_load) begin
                tx_sh     <= load_word;
                o_miso    <= load_lsb ? load_word[0] : load_word[DATA_W-1];
                word_done <= 1'b0;
                if (!o_tx_ready) begin
                    o_tx_ready <= 1'b1;
                end else if (!tx_wr) begin
                    o_underrun <= 1'b1;
                end
            end else if (tx_wr) begin
                tx_buf     <= i_tx_data;
                o_tx_ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_cnt   <= '0;
                    word_done <= 1'b0;
                    o_busy    <= 1'b0;
                    o_miso_oe <= 1'b0;
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        o_busy    <= 1'b1;
                        o_miso_oe <= 1'b1;
                        cpol_l    <= i_cpol;
                        cpha_l    <= i_cpha;
                        lsb_l     <= i_lsb_first;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // Any partial word is dropped
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                        o_miso_oe <= 1'b0;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_sh <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt    <= '0;
                                o_rx_data  <= rx_next;
                                o_rx_valid <= 1'b1;
                                word_done  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (shift_edge && !do_load) begin
                            tx_sh  <= tx_next;
                            o_miso <= miso_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_shift.sv
// Bench for spi_slave_shift: a bit-banged SPI master drives transfers in several modes while a
// scoreboard queue of expected RX words is drained as the DUT reports received words.
module tb_spi_slave_shift;

    localparam int unsigned H = 8;

    logic       clk;
    logic       rst_n;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun;
    logic       busy;

    int tests;
    int fails;
    int rx_seen;
    int rx_spurious;
    int ur_seen;
    logic [7:0] rx_q[$];

    spi_slave_shift #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cpol      (cpol),
        .i_cpha      (cpha),
        .i_lsb_first (lsb_first),
        .i_sclk      (sclk),
        .i_cs_n      (cs_n),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_miso_oe   (miso_oe),
        .i_tx_data   (tx_data),
        .i_tx_valid  (tx_valid),
        .o_tx_ready  (tx_ready),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_underrun  (underrun),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard drain and pulse counters
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_seen++;
                if (rx_q.size() > 0) check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
                else rx_spurious++;
            end
            if (underrun) ur_seen++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input string tag, input logic [7:0] d);
        @(negedge clk);
        check(tag, 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check({tag, "_full"}, 32'(tx_ready), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     32'(miso),     32'd0);
        check({tag, "_miso_oe"},  32'(miso_oe),  32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rx_data"},  32'(rx_data),  32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    // Bit-banged master; m0/m1 collect the MISO words
    task automatic spi_xfer(input logic c_pol, input logic c_pha, input logic lsb,
                            input logic [7:0] w0, input logic [7:0] w1, input int nbits,
                            input bit raise_cs, output logic [7:0] m0, output logic [7:0] m1);
        logic [7:0] w;
        logic [7:0] acc;
        logic       bitv;
        logic       mb;
        int         idx;
        m0 = '0;
        m1 = '0;
        acc = '0;
        cpol = c_pol;
        cpha = c_pha;
        lsb_first = lsb;
        sclk = c_pol;
        wait_clks(H);
        cs_n = 1'b0;
        wait_clks(2 * H);
        for (int b = 0; b < nbits; b++) begin
            w    = (b < 8) ? w0 : w1;
            idx  = b % 8;
            bitv = lsb ? w[idx] : w[7 - idx];
            if (!c_pha) begin
                mosi = bitv;
                wait_clks(H);
                mb   = miso;
                sclk = ~c_pol;
                wait_clks(H);
                sclk = c_pol;
            end else begin
                wait_clks(H);
                sclk = ~c_pol;
                mosi = bitv;
                wait_clks(H);
                mb   = miso;
                sclk = c_pol;
            end
            acc = lsb ? {mb, acc[7:1]} : {acc[6:0], mb};
            if (idx == 7) begin
                if (b < 8) m0 = acc;
                else m1 = acc;
            end
        end
        if (raise_cs) begin
            wait_clks(H);
            cs_n = 1'b1;
            wait_clks(4 * H);
        end
    endtask

    // Full transfer of nwords words with scoreboard pushes and per-transfer checks
    task automatic run_xfer(input string tag, input logic c_pol, input logic c_pha, input logic lsb,
                            input logic [7:0] w0, input logic [7:0] w1, input int nwords,
                            input logic [7:0] exp_m0, input logic [7:0] exp_m1, input int exp_ur);
        logic [7:0] m0;
        logic [7:0] m1;
        int rx0;
        int ur0;
        rx0 = rx_seen;
        ur0 = ur_seen;
        rx_q.push_back(w0);
        if (nwords > 1) rx_q.push_back(w1);
        spi_xfer(c_pol, c_pha, lsb, w0, w1, nwords * 8, 1'b1, m0, m1);
        check({tag, "_miso0"}, 32'(m0), 32'(exp_m0));
        if (nwords > 1) check({tag, "_miso1"}, 32'(m1), 32'(exp_m1));
        check({tag, "_rx_cnt"},   32'(rx_seen - rx0), 32'(nwords));
        check({tag, "_underrun"}, 32'(ur_seen - ur0), 32'(exp_ur));
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_miso_oe"},  32'(miso_oe), 32'd0);
    endtask

    initial begin
        logic [7:0] d0;
        logic [7:0] d1;
        int rx0;
        tests = 0;
        fails = 0;
        rx_seen = 0;
        rx_spurious = 0;
        ur_seen = 0;
        rst_n = 1'b0;
        cpol = 1'b0;
        cpha = 1'b0;
        lsb_first = 1'b0;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        tx_data = '0;
        tx_valid = 1'b0;
        wait_clks(4);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(4);

        // Mode 0 MSB-first; final trailing edge loads the empty buffer once
        tx_write("m0_wr", 8'h3C);
        run_xfer("m0", 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 1);

        // Mode 3 LSB-first; load on first leading edge
        tx_write("m3_wr", 8'h81);
        run_xfer("m3", 1'b1, 1'b1, 1'b1, 8'h5A, 8'h00, 1, 8'h81, 8'h00, 0);

        // Back-to-back under one CS; 0x33 refills the buffer for the closing load
        tx_write("b2b_wr1", 8'h11);
        fork
            run_xfer("b2b", 1'b0, 1'b0, 1'b0, 8'hF0, 8'h0F, 2, 8'h11, 8'h22, 0);
            begin
                wait_clks(5 * H);
                tx_write("b2b_wr2", 8'h22);
                wait_clks(19 * H);
                tx_write("b2b_wr3", 8'h33);
            end
        join

        // Underrun in mode 1: single load with empty buffer
        run_xfer("ur", 1'b0, 1'b1, 1'b0, 8'h96, 8'h00, 1, 8'h00, 8'h00, 1);

        // Abort after three sample edges
        rx0 = rx_seen;
        spi_xfer(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 3, 1'b1, d0, d1);
        check("abort_rx_cnt", 32'(rx_seen - rx0), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tx_write("abort_wr", 8'h5D);
        run_xfer("post_abort", 1'b0, 1'b0, 1'b0, 8'hC3, 8'h00, 1, 8'h5D, 8'h00, 1);

        // Reset mid-transfer after five bits
        tx_write("rst_wr", 8'h42);
        spi_xfer(1'b0, 1'b0, 1'b0, 8'hB7, 8'h00, 5, 1'b0, d0, d1);
        check("rst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #3;
        check_reset_outputs("midrst");
        cs_n = 1'b1;
        sclk = 1'b0;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(5);
        tx_write("post_rst_wr", 8'h24);
        run_xfer("post_rst", 1'b0, 1'b0, 1'b0, 8'h7E, 8'h00, 1, 8'h24, 8'h00, 1);

        wait_clks(10);
        check("rx_spurious", 32'(rx_spurious), 32'd0);
        check("rx_q_left", 32'(rx_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
